vip_window_ctrl: RTL and testbench
==================================

# vip_window_ctrl

Sequencing controller for the 3x3 window stage of the Sobel path. It sits directly after the 3x3 matrix generator and consumes that generator's delayed frame_vsync/href/clken. It tracks column/row position, measures line and frame size, and qualifies each window with a valid flag plus centre coordinates so the Sobel core discards border windows built from zero-filled or stale taps. It also flags line-length inconsistencies.

## Interface
- MAX_W, 2048: maximum pixels per line; column counters are $clog2(MAX_W+1) bits wide.
- MAX_H, 2048: maximum lines per frame; row counters are $clog2(MAX_H+1) bits wide.
- VS_POL, 1: active level of vsync (1 = active-high).
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mat_vsync  in  1  frame sync from matrix generator.
- mat_href  in  1  line valid from matrix generator.
- mat_clken  in  1  pixel strobe from matrix generator; counted only while mat_href=1.
- win_vsync / win_href / win_clken  out  1 each  inputs delayed by one register.
- win_valid  out  1  window is fully inside the image; downstream consumes only when win_valid=1.
- win_col  out  CW  centre column of the current window (0-based).
- win_row  out  RW  centre row of the current window (0-based).
- line_len  out  CW  pixel count of the first line of the current frame.
- frame_lines  out  RW  line count of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame closes.
- len_err  out  1  sticky line-length error; cleared at frame start.

## Operation
- FSM states:
  - IDLE, the reset state: waits for vsync to become active.
  - SYNC: vsync is active. On deassertion, clear col, row and len_err, then go to FIRST.
  - FIRST: counts the first line. On href falling edge, latch line_len = col, set row=1, go to ACTIVE.
  - ACTIVE: on each href falling edge, row++ and col=0. If col != line_len, set len_err.
- Vsync becoming active from FIRST or ACTIVE:
  - If row > 0, load frame_lines = row and pulse frame_done.
  - Then go to SYNC.
- col counts mat_clken while mat_href=1. It saturates at MAX_W and sets len_err on overflow.
- row saturates at MAX_H and sets len_err on overflow.
- Position of the newest pixel is (col, row), counted before the increment.
- win_valid = clken & href & (col >= 2) & (row >= 2) & state ∈ {FIRST, ACTIVE}.
  - In practice win_valid only asserts in ACTIVE, because row >= 2 is required.
- Window centre coordinates: win_col = col-1, win_row = row-1. These are valid only when win_valid=1 and hold their value otherwise.
- mat_clken while mat_href=0 is ignored.
- Simultaneous href falling edge and vsync activation: the line-end update (row++, length compare) is applied first. frame_lines then includes that line.
- A line with zero pixels (href pulse with no clken) still counts as a line and is compared against line_len.

## Timing
- All outputs are registered, with one cycle of latency from the mat_* inputs.
- The Sobel core adds one matching register stage on the matrix taps.
- Reset values:
  - all outputs 0; state = IDLE.
- Assertion of rst_n mid-frame: FSM returns to IDLE. win_valid stays 0 until a complete vsync active/inactive sequence has been seen; the partial frame is never qualified.
- frame_done is asserted for exactly one cycle, in the cycle after vsync is sampled active.
- len_err asserts in the cycle after the offending href falling edge or overflow.
- Back-to-back clken (every cycle) is supported with no stalls.

## Structure
- Shared package vip_pkg holds:
  - window-state enum (IDLE, SYNC, FIRST, ACTIVE);
  - the default MAX_W/MAX_H constants;
  - the window radius constant (1), from which the col >= 2 / row >= 2 bounds are derived.
- One natural sub-module: vip_edge_det, for the registered rise/fall detection of vsync and href. It is instantiated twice.
- Counters and the FSM stay in vip_window_ctrl.

## Test plan
- Reset mid-frame during a 640x4 frame -> all outputs 0. No win_valid until after the next vsync pulse. The next frame's counts are correct.
- 8x6 frame, continuous clken -> win_valid high for 6 windows per line on rows 2-5 (24 total). First valid window has win_col=1, win_row=1; last has win_col=6, win_row=4. frame_lines=6, line_len=8, one frame_done pulse.
- 8x6 frame, clken every other cycle -> same 24 valid windows and coordinates. win_valid is never high on a cycle where clken is low.
- Line 3 with 7 pixels (others 8) -> len_err rises after line 3 ends and stays high. It is cleared by the next frame's vsync deassertion.
- href falls in the same cycle vsync asserts, on the 6th line -> frame_lines=6, frame_done pulses once.
- MAX_W=16, 20-pixel line -> col saturates at 16 and len_err is set. win_col never exceeds 15.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared types and constants for the Sobel 3x3 window sequencing path.
package vip_pkg;

  typedef enum logic [1:0] {
    WIN_IDLE,
    WIN_SYNC,
    WIN_FIRST,
    WIN_ACTIVE
  } win_state_e;

  localparam int unsigned VIP_MAX_W  = 2048;
  localparam int unsigned VIP_MAX_H  = 2048;
  localparam int unsigned WIN_RADIUS = 1;
  // Newest pixel must be at least a full window width from the image origin.
  localparam int unsigned WIN_EDGE_MIN = 2 * WIN_RADIUS;

endpackage

// File: rtl/vip_edge_det.sv
// Registered change detector: delays the input one cycle and flags any level change.
module vip_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_dly,
  output logic chg
);

  logic sig_d;
  logic sig_q;

  always_comb begin
    sig_d = sig_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_dly = sig_q;
  // Rise/fall are recovered by the user from chg and the current input level.
  assign chg     = sig_in ^ sig_q;

endmodule

// File: rtl/vip_window_ctrl.sv
// 3x3 window sequencer: tracks pixel position, measures line/frame size and
// qualifies interior windows with centre coordinates for the Sobel core.
module vip_window_ctrl
  import vip_pkg::*;
#(
  parameter int unsigned MAX_W  = VIP_MAX_W,
  parameter int unsigned MAX_H  = VIP_MAX_H,
  parameter bit          VS_POL = 1'b1,
  localparam int unsigned CW    = $clog2(MAX_W + 1),
  localparam int unsigned RW    = $clog2(MAX_H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mat_vsync,
  input  logic          mat_href,
  input  logic          mat_clken,
  output logic          win_vsync,
  output logic          win_href,
  output logic          win_clken,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] line_len,
  output logic [RW-1:0] frame_lines,
  output logic          frame_done,
  output logic          len_err
);

  localparam logic [CW-1:0] COL_MIN = CW'(WIN_EDGE_MIN);
  localparam logic [RW-1:0] ROW_MIN = RW'(WIN_EDGE_MIN);
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(MAX_H);
  localparam logic [CW-1:0] COL_OFS = CW'(WIN_RADIUS);
  localparam logic [RW-1:0] ROW_OFS = RW'(WIN_RADIUS);

  win_state_e    state_d, state_q;
  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic [CW-1:0] line_len_d, line_len_q;
  logic [RW-1:0] frame_lines_d, frame_lines_q;
  logic          len_err_d, len_err_q;
  logic          frame_done_d, frame_done_q;
  logic          win_valid_d, win_valid_q;
  logic [CW-1:0] win_col_d, win_col_q;
  logic [RW-1:0] win_row_d, win_row_q;
  logic          clken_d, clken_q;

  logic vs_dly, vs_chg, hr_dly, hr_chg;
  logic vs_act, vs_start, vs_end, hr_fall, pix, in_frame;

  vip_edge_det u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (mat_vsync),
    .sig_dly(vs_dly),
    .chg    (vs_chg)
  );

  vip_edge_det u_hr_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (mat_href),
    .sig_dly(hr_dly),
    .chg    (hr_chg)
  );

  assign vs_act   = (mat_vsync == VS_POL);
  assign vs_start = vs_chg & vs_act;
  assign vs_end   = vs_chg & ~vs_act;
  assign hr_fall  = hr_chg & ~mat_href;
  assign pix      = mat_href & mat_clken;
  assign in_frame = (state_q == WIN_FIRST) || (state_q == WIN_ACTIVE);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    len_err_d     = len_err_q;
    frame_done_d  = 1'b0;
    win_valid_d   = 1'b0;
    win_col_d     = win_col_q;
    win_row_d     = win_row_q;
    clken_d       = mat_clken;

    // Pixel position is taken before the increment; saturated pixels still form windows.
    if (in_frame && pix) begin
      if ((col_q >= COL_MIN) && (row_q >= ROW_MIN)) begin
        win_valid_d = 1'b1;
        win_col_d   = col_q - COL_OFS;
        win_row_d   = row_q - ROW_OFS;
      end
      if (col_q == COL_MAX) begin
        len_err_d = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      WIN_IDLE: begin
        if (vs_act) begin
          state_d = WIN_SYNC;
        end
      end
      WIN_SYNC: begin
        if (vs_end) begin
          col_d     = '0;
          row_d     = '0;
          len_err_d = 1'b0;
          state_d   = WIN_FIRST;
        end
      end
      WIN_FIRST, WIN_ACTIVE: begin
        if (hr_fall) begin
          col_d = '0;
          if (state_q == WIN_FIRST) begin
            line_len_d = col_q;
            row_d      = RW'(1);
            state_d    = WIN_ACTIVE;
          end else begin
            if (col_q != line_len_q) begin
              len_err_d = 1'b1;
            end
            if (row_q == ROW_MAX) begin
              len_err_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
        // Frame close sees row_d, so a line ending on the same cycle is included.
        if (vs_start) begin
          if (row_d != '0) begin
            frame_lines_d = row_d;
            frame_done_d  = 1'b1;
          end
          state_d = WIN_SYNC;
        end
      end
      default: state_d = WIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WIN_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      len_err_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      win_valid_q   <= 1'b0;
      win_col_q     <= '0;
      win_row_q     <= '0;
      clken_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      len_err_q     <= len_err_d;
      frame_done_q  <= frame_done_d;
      win_valid_q   <= win_valid_d;
      win_col_q     <= win_col_d;
      win_row_q     <= win_row_d;
      clken_q       <= clken_d;
    end
  end

  assign win_vsync   = vs_dly;
  assign win_href    = hr_dly;
  assign win_clken   = clken_q;
  assign win_valid   = win_valid_q;
  assign win_col     = win_col_q;
  assign win_row     = win_row_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_done  = frame_done_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_vip_window_ctrl.sv
// Directed bench for vip_window_ctrl: default-size instance plus a MAX_W=16 instance.
module tb_vip_window_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mat_vsync = 1'b0;
  logic mat_href = 1'b0;
  logic mat_clken = 1'b0;

  always #5 clk = ~clk;

  logic        w_vsync, w_href, w_clken, w_valid, w_done, w_err;
  logic [11:0] w_col, w_len;
  logic [11:0] w_row, w_lines;

  logic        s_vsync, s_href, s_clken, s_valid, s_done, s_err;
  logic [4:0]  s_col, s_len;
  logic [4:0]  s_row, s_lines;

  vip_window_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mat_vsync(mat_vsync), .mat_href(mat_href), .mat_clken(mat_clken),
    .win_vsync(w_vsync), .win_href(w_href), .win_clken(w_clken),
    .win_valid(w_valid), .win_col(w_col), .win_row(w_row),
    .line_len(w_len), .frame_lines(w_lines), .frame_done(w_done), .len_err(w_err)
  );

  vip_window_ctrl #(.MAX_W(16), .MAX_H(16)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .mat_vsync(mat_vsync), .mat_href(mat_href), .mat_clken(mat_clken),
    .win_vsync(s_vsync), .win_href(s_href), .win_clken(s_clken),
    .win_valid(s_valid), .win_col(s_col), .win_row(s_row),
    .line_len(s_len), .frame_lines(s_lines), .frame_done(s_done), .len_err(s_err)
  );

  int checks = 0;
  int failures = 0;
  int n_valid, n_done, n_bad, fc, fr, lc, lr, s_maxcol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_valid = 0; n_done = 0; n_bad = 0;
    fc = -1; fr = -1; lc = -1; lr = -1; s_maxcol = 0;
  endtask

  // Advance one clock; outputs seen at +1 reflect the inputs held across that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (w_valid === 1'b1) begin
      if (n_valid == 0) begin
        fc = int'(w_col);
        fr = int'(w_row);
      end
      lc = int'(w_col);
      lr = int'(w_row);
      n_valid++;
      if (!(mat_clken && mat_href)) n_bad++;
    end
    if (w_done === 1'b1) n_done++;
    if (s_valid === 1'b1 && int'(s_col) > s_maxcol) s_maxcol = int'(s_col);
  endtask

  task automatic vs_pulse();
    mat_vsync = 1'b1; mat_href = 1'b0; mat_clken = 1'b0;
    tick(); tick();
    mat_vsync = 1'b0;
    tick(); tick();
  endtask

  task automatic line(input int len, input bit alt, input bit merge);
    mat_href = 1'b1;
    if (len == 0) begin
      mat_clken = 1'b0;
      tick();
    end
    for (int p = 0; p < len; p++) begin
      mat_clken = 1'b1;
      tick();
      if (alt) begin
        mat_clken = 1'b0;
        tick();
      end
    end
    mat_href = 1'b0;
    mat_clken = 1'b0;
    if (merge) begin
      mat_vsync = 1'b1;
      tick(); tick();
      mat_vsync = 1'b0;
      tick(); tick();
    end else begin
      tick(); tick();
    end
  endtask

  initial begin
    clr_stats();
    // Power-on reset
    repeat (3) tick();
    chk("rst_valid", w_valid, 0);
    chk("rst_col_row", {w_col, w_row}, 0);
    chk("rst_len_lines", {w_len, w_lines}, 0);
    chk("rst_flags", {w_done, w_err, w_vsync, w_href, w_clken}, 0);
    rst_n = 1'b1;

    // Reset in the middle of line 3 of a 640x4 frame
    vs_pulse();
    line(640, 0, 0);
    line(640, 0, 0);
    chk("len_before_rst", w_len, 640);
    mat_href = 1'b1; mat_clken = 1'b1;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", w_valid, 0);
    chk("midrst_len", w_len, 0);
    chk("midrst_col_row", {w_col, w_row}, 0);
    chk("midrst_flags", {w_done, w_err, w_vsync, w_href, w_clken}, 0);
    tick();
    rst_n = 1'b1;
    clr_stats();
    repeat (540) tick();
    mat_href = 1'b0; mat_clken = 1'b0;
    tick(); tick();
    line(640, 0, 0);
    vs_pulse();
    chk("partial_valid", n_valid, 0);
    chk("partial_done", n_done, 0);
    chk("partial_lines", w_lines, 0);
    clr_stats();
    repeat (4) line(640, 0, 0);
    vs_pulse();
    chk("f640_lines", w_lines, 4);
    chk("f640_len", w_len, 640);
    chk("f640_valid", n_valid, 1276);
    chk("f640_last", {lc[15:0], lr[15:0]}, {16'd638, 16'd2});
    chk("f640_done", n_done, 1);
    chk("f640_err", w_err, 0);

    // 8x6 continuous clken
    clr_stats();
    repeat (6) line(8, 0, 0);
    vs_pulse();
    chk("c8_valid", n_valid, 24);
    chk("c8_first", {fc[15:0], fr[15:0]}, {16'd1, 16'd1});
    chk("c8_last", {lc[15:0], lr[15:0]}, {16'd6, 16'd4});
    chk("c8_lines", w_lines, 6);
    chk("c8_len", w_len, 8);
    chk("c8_done", n_done, 1);
    chk("c8_err", w_err, 0);
    chk("c8_col_hold", w_col, 6);

    // 8x6 with clken every other cycle
    clr_stats();
    repeat (6) line(8, 1, 0);
    vs_pulse();
    chk("a8_valid", n_valid, 24);
    chk("a8_first", {fc[15:0], fr[15:0]}, {16'd1, 16'd1});
    chk("a8_last", {lc[15:0], lr[15:0]}, {16'd6, 16'd4});
    chk("a8_no_clken_valid", n_bad, 0);
    chk("a8_lines_len", {w_lines, w_len}, {12'd6, 12'd8});
    chk("a8_done", n_done, 1);

    // Third line short by one pixel, 5-line frame
    clr_stats();
    line(8, 0, 0);
    line(8, 0, 0);
    chk("short_err_before", w_err, 0);
    line(7, 0, 0);
    chk("short_err_set", w_err, 1);
    line(8, 0, 0);
    line(8, 0, 0);
    chk("short_err_sticky", w_err, 1);
    mat_vsync = 1'b1;
    tick(); tick();
    chk("short_err_in_vs", w_err, 1);
    chk("short_lines", w_lines, 5);
    mat_vsync = 1'b0;
    tick();
    chk("short_err_clear", w_err, 0);
    tick();

    // href falls in the same cycle vsync asserts, on the 6th line
    clr_stats();
    repeat (5) line(8, 0, 0);
    line(8, 0, 1);
    chk("merge_lines", w_lines, 6);
    chk("merge_done", n_done, 1);
    chk("merge_err", w_err, 0);

    // 20-pixel lines into the MAX_W=16 instance
    clr_stats();
    line(20, 0, 0);
    chk("sat_err", s_err, 1);
    chk("sat_len", s_len, 16);
    line(20, 0, 0);
    line(20, 0, 0);
    vs_pulse();
    chk("sat_max_col", s_maxcol, 15);
    chk("sat_lines", s_lines, 3);
    chk("big_len20", {w_len, 11'd0, w_err}, {12'd20, 12'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
